alu_muldiv_seq: RTL and testbench

//   Parametrised execute unit, successor of the single-cycle 32-bit ALU. Adds RV32M-style

---
 rtl/alu_muldiv_seq_pkg.sv | 22 ++
 rtl/alu_muldiv_seq_alu.sv | 31 +++
 rtl/alu_muldiv_seq.sv | 95 +++++++++
 tb/tb_alu_muldiv_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// alu_muldiv_seq_pkg: shared op encodings, FSM states and md op decode helpers
package alu_muldiv_seq_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
  function automatic logic md_is_div(input md_op_t op);
    return op[2];
  endfunction
  function automatic logic md_is_rem(input md_op_t op);
    return op[2] & op[1];
  endfunction
  function automatic logic md_signed_a(input md_op_t op);
    return op[2] ? !op[0] : (op == MD_MULH || op == MD_MULHSU);
  endfunction
  function automatic logic md_signed_b(input md_op_t op);
    return op[2] ? !op[0] : (op == MD_MULH);
  endfunction
endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// alu_comb: generic single-cycle base ALU (add/sub/shift/compare/logic)
module alu_comb
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(WIDTH-1){1'b0}}, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = $unsigned($signed(a) >>> sh);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: execute unit with 1-cycle ALU and iterative RV32M-style mul/div behind valid/ready
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_md,
  input  alu_op_t          alu_op,
  input  md_op_t           md_op,
  input  logic [WIDTH-1:0] arg_1,
  input  logic [WIDTH-1:0] arg_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  md_state_t state, state_n;
  md_op_t op;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, opnd, hi_n, lo_n, alu_y, early_y, md_y, mag_a, mag_b, q, r;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0] msum, dsh, ddiff;
  logic neg_a, neg_b, sa_neg, sb_neg, accept, last, div0, ovf, early;
  alu_comb #(.WIDTH(WIDTH)) u_alu (.op(alu_op), .a(arg_1), .b(arg_2), .y(alu_y));
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready && !flush;
  assign last = state == BUSY && cnt == CW'(WIDTH - 1);
  assign sa_neg = md_signed_a(md_op) && arg_1[WIDTH-1];
  assign sb_neg = md_signed_b(md_op) && arg_2[WIDTH-1];
  assign mag_a = sa_neg ? -arg_1 : arg_1;
  assign mag_b = sb_neg ? -arg_2 : arg_2;
  assign div0 = md_is_div(md_op) && arg_2 == '0;
  assign ovf = md_is_div(md_op) && md_signed_a(md_op) && arg_1 == MIN && arg_2 == '1;
  assign early = is_md && (div0 || ovf);
  assign early_y = div0 ? (md_is_rem(md_op) ? arg_1 : '1) : (md_is_rem(md_op) ? '0 : MIN);
  always_comb begin
    msum = {1'b0, hi} + {1'b0, {WIDTH{lo[0]}} & opnd};
    dsh = {hi, lo[WIDTH-1]};
    ddiff = dsh - {1'b0, opnd};
    hi_n = md_is_div(op) ? (ddiff[WIDTH] ? dsh[WIDTH-1:0] : ddiff[WIDTH-1:0]) : msum[WIDTH:1];
    lo_n = md_is_div(op) ? {lo[WIDTH-2:0], !ddiff[WIDTH]} : {msum[0], lo[WIDTH-1:1]};
    prod = (neg_a ^ neg_b) ? -{hi_n, lo_n} : {hi_n, lo_n};
    q = (neg_a ^ neg_b) ? -lo_n : lo_n;
    r = neg_a ? -hi_n : hi_n;
    md_y = md_is_div(op) ? (md_is_rem(op) ? r : q)
         : (op == MD_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
  end
  always_comb begin
    state_n = flush ? IDLE
            : accept ? ((!is_md || early) ? DONE : BUSY)
            : last ? DONE
            : (out_valid && out_ready) ? IDLE
            : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      opnd <= '0;
      result <= '0;
      op <= MD_MUL;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      op <= md_op;
      neg_a <= sa_neg;
      neg_b <= sb_neg;
      cnt <= '0;
      hi <= '0;
      lo <= md_is_div(md_op) ? mag_a : mag_b;
      opnd <= md_is_div(md_op) ? mag_b : mag_a;
      if (!is_md) result <= alu_y;
      else if (early) result <= early_y;
    end else if (state == BUSY) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt + 1'b1;
      if (last) result <= md_y;
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed table-driven bench for alu_muldiv_seq at WIDTH=32
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;
  logic clk, rst, flush, in_valid, in_ready, is_md, out_valid, out_ready;
  alu_op_t alu_op;
  md_op_t md_op;
  logic [31:0] arg_1, arg_2, result;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic md;
    alu_op_t aop;
    md_op_t mop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int lat;
  } vec_t;
  vec_t vecs[$];
  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .is_md(is_md), .alu_op(alu_op), .md_op(md_op), .arg_1(arg_1), .arg_2(arg_2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask
  task automatic run_op(input logic md, input alu_op_t aop, input md_op_t mop,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic rdy_seen);
    is_md = md;
    alu_op = aop;
    md_op = mop;
    arg_1 = a;
    arg_2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      rdy_seen |= in_ready;
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
  task automatic start_op(input md_op_t mop, input logic [31:0] a, input logic [31:0] b);
    is_md = 1'b1;
    md_op = mop;
    arg_1 = a;
    arg_2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  initial begin
    logic [31:0] res;
    int lat, w;
    logic rdy;
    vecs.push_back('{1'b0, ALU_ADD,  MD_MUL,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    vecs.push_back('{1'b0, ALU_SUB,  MD_MUL,    32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1});
    vecs.push_back('{1'b0, ALU_SRA,  MD_MUL,    32'h80000000, 32'h00000004, 32'hF8000000, 1});
    vecs.push_back('{1'b0, ALU_SLL,  MD_MUL,    32'h00000001, 32'h00000024, 32'h00000010, 1});
    vecs.push_back('{1'b0, ALU_SLT,  MD_MUL,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
    vecs.push_back('{1'b0, ALU_SLTU, MD_MUL,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    vecs.push_back('{1'b0, ALU_XOR,  MD_MUL,    32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1});
    vecs.push_back('{1'b0, ALU_SRL,  MD_MUL,    32'h80000000, 32'h00000004, 32'h08000000, 1});
    vecs.push_back('{1'b0, ALU_AND,  MD_MUL,    32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1});
    vecs.push_back('{1'b0, ALU_OR,   MD_MUL,    32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 1});
    vecs.push_back('{1'b1, ALU_ADD,  MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33});
    vecs.push_back('{1'b1, ALU_ADD,  MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back('{1'b1, ALU_ADD,  MD_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33});
    vecs.push_back('{1'b1, ALU_ADD,  MD_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33});
    vecs.push_back('{1'b1, ALU_ADD,  MD_MUL,    32'h00003039, 32'hFFFFFFFD, 32'hFFFF6F55, 33});
    vecs.push_back('{1'b1, ALU_ADD,  MD_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
    vecs.push_back('{1'b1, ALU_ADD,  MD_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
    vecs.push_back('{1'b1, ALU_ADD,  MD_DIVU,   32'd100,      32'd7,        32'd14,       33});
    vecs.push_back('{1'b1, ALU_ADD,  MD_REMU,   32'd100,      32'd7,        32'd2,        33});
    vecs.push_back('{1'b1, ALU_ADD,  MD_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
    vecs.push_back('{1'b1, ALU_ADD,  MD_DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{1'b1, ALU_ADD,  MD_REM,    32'h00000005, 32'h00000000, 32'h00000005, 1});
    vecs.push_back('{1'b1, ALU_ADD,  MD_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{1'b1, ALU_ADD,  MD_REMU,   32'h00000005, 32'h00000000, 32'h00000005, 1});
    vecs.push_back('{1'b1, ALU_ADD,  MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{1'b1, ALU_ADD,  MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    vecs.push_back('{1'b1, ALU_ADD,  MD_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
    vecs.push_back('{1'b1, ALU_ADD,  MD_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    is_md = 1'b0;
    alu_op = ALU_ADD;
    md_op = MD_MUL;
    arg_1 = '0;
    arg_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    foreach (vecs[i]) begin
      run_op(vecs[i].md, vecs[i].aop, vecs[i].mop, vecs[i].a, vecs[i].b, res, lat, rdy);
      chk($sformatf("vec%0d result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      if (vecs[i].lat > 1) chk($sformatf("vec%0d in_ready while busy", i), {31'b0, rdy}, 32'd0);
    end
    start_op(MD_MUL, 32'd3, 32'd4);
    w = 1;
    while (!out_valid && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("bp mul latency", w, 33);
    is_md = 1'b0;
    alu_op = ALU_ADD;
    arg_1 = 32'd1;
    arg_2 = 32'd1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d result", k), result, 32'd12);
      chk($sformatf("bp%0d out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp%0d in_ready", k), {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp release out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
    is_md = 1'b0;
    alu_op = ALU_ADD;
    arg_1 = 32'd2;
    arg_2 = 32'd3;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("idle flush drops input out_valid", {31'b0, out_valid}, 32'd0);
    chk("idle flush in_ready", {31'b0, in_ready}, 32'd1);
    start_op(MD_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    chk("divu busy before flush", {31'b0, in_ready}, 32'd0);
    is_md = 1'b0;
    alu_op = ALU_ADD;
    arg_1 = 32'd2;
    arg_2 = 32'd3;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("flush no late out_valid", {31'b0, out_valid}, 32'd0);
    run_op(1'b1, ALU_ADD, MD_DIVU, 32'd100, 32'd7, res, lat, rdy);
    chk("post-flush divu result", res, 32'd14);
    chk("post-flush divu latency", lat, 33);
    start_op(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid rst result", result, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("mid rst no late out_valid", {31'b0, out_valid}, 32'd0);
    run_op(1'b1, ALU_ADD, MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, rdy);
    chk("post-rst mulhu result", res, 32'hFFFFFFFE);
    chk("post-rst mulhu latency", lat, 33);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
